// File: rtl/cic_fir_pkg.sv
// Shared types, default coefficient set and width helper for the CIC
// compensation FIR.
package cic_fir_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_ROUND, ST_OUT} fir_state_t;

  localparam int FIR_NUM_TAPS = 15;

  // Symmetric, sums to 2**17 (unity DC); alternating sum 132928 lifts Nyquist
  localparam logic signed [17:0] FIR_COEFFS [FIR_NUM_TAPS] = '{
    18'sd2000, -18'sd1000, 18'sd4000, -18'sd3000, 18'sd20000, -18'sd8000,
    18'sd40000, 18'sd23072, 18'sd40000, -18'sd8000, 18'sd20000, -18'sd3000,
    18'sd4000, -18'sd1000, 18'sd2000
  };

  function automatic int acc_width(input int in_w, input int coeff_w, input int taps);
    return in_w + coeff_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_round_saturate.sv
// Combinational round-half-up, arithmetic shift and clamp of a wide
// accumulator down to a signed output word.
module fir_round_saturate #(
  parameter int ACC_W     = 38,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 17
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] result
);

  localparam int W = ACC_W + 1;
  localparam logic signed [W-1:0] HALF  = W'(2 ** (FRAC_BITS - 1));
  localparam logic signed [W-1:0] MAX_V = W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;

  logic signed [W-1:0] biased, shifted;

  // One guard bit so the rounding bias can never wrap the accumulator
  assign biased  = {acc[ACC_W-1], acc} + HALF;
  assign shifted = biased >>> FRAC_BITS;

  always_comb begin
    result = shifted[OUT_W-1:0];
    if (shifted > MAX_V)      result = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V) result = MIN_V[OUT_W-1:0];
  end

endmodule

// File: rtl/cic_compensation_fir.sv
// Decimated-rate CIC droop compensation FIR: one time-shared MAC over a
// circular sample buffer. CIC_FIR_SYMMETRIC_EN folds symmetric taps (pre-add).
module cic_compensation_fir
  import cic_fir_pkg::*;
#(
  parameter int NUM_TAPS        = 15,
  parameter int NUM_BITS_INPUT  = 16,
  parameter int NUM_BITS_OUTPUT = 16,
  parameter int NUM_BITS_COEFF  = 18,
  parameter int COEFF_FRAC_BITS = 17
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              tick_i,
  input  logic signed [NUM_BITS_INPUT-1:0]  signal_i,
  output logic signed [NUM_BITS_OUTPUT-1:0] signal_o,
  output logic                              tick_o,
  output logic                              busy_o,
  output logic                              overrun_o
);

  localparam int ACC_W = acc_width(NUM_BITS_INPUT, NUM_BITS_COEFF, NUM_TAPS);
  localparam int PW    = $clog2(NUM_TAPS);
  localparam int PRW   = NUM_BITS_INPUT + NUM_BITS_COEFF + 1;
`ifdef CIC_FIR_SYMMETRIC_EN
  localparam int NUM_COEFFS = (NUM_TAPS + 1) / 2;
`else
  localparam int NUM_COEFFS = NUM_TAPS;
`endif
  localparam int CW = $clog2(NUM_COEFFS);
  localparam logic [PW-1:0] K_LAST = PW'(NUM_COEFFS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_TAPS - 1);

  fir_state_t state, state_nxt;

  logic signed [NUM_BITS_COEFF-1:0]  coeff_rom [NUM_COEFFS];
  logic signed [NUM_BITS_INPUT-1:0]  sbuf [NUM_TAPS];
  logic [PW-1:0]                     wr_ptr, rd_new, k;
  logic signed [ACC_W-1:0]           acc;
  logic signed [NUM_BITS_INPUT:0]    mac_x;
  logic signed [PRW-1:0]             prod;
  logic signed [NUM_BITS_OUTPUT-1:0] rounded, sig_q;
  logic                              ovr_q;
`ifdef CIC_FIR_SYMMETRIC_EN
  logic [PW-1:0]                     rd_old;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? P_LAST : p - 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_COEFFS; i++) begin : g_coeff
    assign coeff_rom[i] = NUM_BITS_COEFF'(FIR_COEFFS[i]);
  end

  // rd_new walks back from the newest sample; rd_old walks forward from the oldest
`ifdef CIC_FIR_SYMMETRIC_EN
  always_comb begin
    mac_x = {sbuf[rd_new][NUM_BITS_INPUT-1], sbuf[rd_new]};
    if (k != K_LAST)
      mac_x = mac_x + {sbuf[rd_old][NUM_BITS_INPUT-1], sbuf[rd_old]};
  end
`else
  assign mac_x = {sbuf[rd_new][NUM_BITS_INPUT-1], sbuf[rd_new]};
`endif

  assign prod = PRW'(mac_x) * PRW'(coeff_rom[k[CW-1:0]]);

  fir_round_saturate #(
    .ACC_W    (ACC_W),
    .OUT_W    (NUM_BITS_OUTPUT),
    .FRAC_BITS(COEFF_FRAC_BITS)
  ) u_rnd (
    .acc   (acc),
    .result(rounded)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick_i) state_nxt = ST_MAC;
      ST_MAC:   if (k == K_LAST) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_new <= '0;
      k      <= '0;
      acc    <= '0;
      sig_q  <= '0;
      ovr_q  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) sbuf[i] <= '0;
`ifdef CIC_FIR_SYMMETRIC_EN
      rd_old <= '0;
`endif
    end else begin
      // OUT counts as busy, so a tick there is dropped too
      if (tick_i && state != ST_IDLE) ovr_q <= 1'b1;
      case (state)
        ST_IDLE: if (tick_i) begin
          sbuf[wr_ptr] <= signal_i;
          rd_new       <= wr_ptr;
          wr_ptr       <= ptr_inc(wr_ptr);
          acc          <= '0;
          k            <= '0;
`ifdef CIC_FIR_SYMMETRIC_EN
          rd_old       <= ptr_inc(wr_ptr);
`endif
        end
        ST_MAC: begin
          acc    <= acc + ACC_W'(prod);
          rd_new <= ptr_dec(rd_new);
          if (k != K_LAST) k <= k + 1'b1;
`ifdef CIC_FIR_SYMMETRIC_EN
          rd_old <= ptr_inc(rd_old);
`endif
        end
        ST_ROUND: sig_q <= rounded;
        default: ;
      endcase
    end
  end

  assign signal_o  = sig_q;
  assign tick_o    = (state == ST_OUT);
  assign busy_o    = (state != ST_IDLE);
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_cic_compensation_fir.sv
// Directed-vector bench for cic_compensation_fir: impulse, DC, saturation
// tables plus overrun, mid-MAC reset and minimum-spacing random sequences.
module tb_cic_compensation_fir;

  localparam int N = 15;
`ifdef CIC_FIR_SYMMETRIC_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 17;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic tick_i = 1'b0;
  logic signed [15:0] signal_i = '0;
  logic signed [15:0] signal_o;
  logic tick_o, busy_o, overrun_o;

  always #5 clk = ~clk;

  cic_compensation_fir dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .tick_i   (tick_i),
    .signal_i (signal_i),
    .signal_o (signal_o),
    .tick_o   (tick_o),
    .busy_o   (busy_o),
    .overrun_o(overrun_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tick_cnt = 0, wide_cnt = 0;
  logic prev_tick = 1'b0;
  always @(negedge clk) begin
    if (tick_o) begin
      tick_cnt <= tick_cnt + 1;
      if (prev_tick) wide_cnt <= wide_cnt + 1;
    end
    prev_tick <= tick_o;
  end

  int n_pass = 0, n_tot = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: direct convolution with round-half-up and clamp
  longint coef [N] = '{2000, -1000, 4000, -3000, 20000, -8000, 40000, 23072,
                       40000, -8000, 20000, -3000, 4000, -1000, 2000};
  longint hist [N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) hist[i] = 0;
  endtask

  task automatic model_push(input longint x);
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  function automatic longint model_out();
    longint y, r;
    y = 0;
    for (int i = 0; i < N; i++) y += coef[i] * hist[i];
    r = (y + 65536) >>> 17;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    tick_i  = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    model_clear();
  endtask

  // Called at a negedge; returns at the negedge `spacing` cycles after the tick
  task automatic apply(input logic signed [15:0] x, input int spacing,
                       output logic got, output int lat, output longint val);
    int t0;
    tick_i   = 1'b1;
    signal_i = x;
    t0       = cyc;
    @(negedge clk);
    tick_i = 1'b0;
    got = 1'b0;
    lat = -1;
    val = 0;
    while (!got && (cyc - t0) <= LAT + 5) begin
      if (tick_o) begin
        got = 1'b1;
        lat = cyc - t0;
        val = signal_o;
      end else @(negedge clk);
    end
    while ((cyc - t0) < spacing) @(negedge clk);
  endtask

  typedef struct {
    bit                 rst;
    logic signed [15:0] x;
    bit                 chk;
    logic signed [15:0] y;
  } vec_t;

  vec_t vq[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint imp [16] = '{250, -125, 500, -375, 2500, -1000, 5000, 2884,
                         5000, -1000, 2500, -375, 500, -125, 250, 0};
    longint dc  [15] = '{15, 8, 38, 15, 168, 107, 412, 588,
                         893, 832, 985, 962, 992, 985, 1000};
    logic signed [15:0] pmax, pmin, xs;
    logic   got;
    int     lat, t0, base;
    longint val, exp_v;

    pmax = 16'sh7FFF;
    pmin = 16'sh8000;
    for (int i = 0; i < 16; i++)
      vq.push_back('{(i == 0), (i == 0) ? 16'sd16384 : 16'sd0, 1'b1, 16'(imp[i])});
    for (int i = 0; i < 18; i++)
      vq.push_back('{(i == 0), 16'sd1000, 1'b1, (i < 15) ? 16'(dc[i]) : 16'sd1000});
    for (int i = 0; i < 18; i++)
      vq.push_back('{(i == 0), (i % 2 == 0) ? pmax : pmin, (i >= 14), (i % 2 == 0) ? pmax : pmin});

    repeat (3) @(negedge clk);
    check("rst_signal_o", signal_o, 0);
    check("rst_tick_o", tick_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_overrun_o", overrun_o, 0);
    reset_i = 1'b0;
    model_clear();
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      apply(vq[i].x, 20, got, lat, val);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      if (vq[i].chk) check($sformatf("vec%0d_value", i), val, vq[i].y);
    end

    // Second tick 3 clocks into the sequence must be dropped
    do_reset();
    base = tick_cnt;
    tick_i = 1'b1; signal_i = 16'sd16384; t0 = cyc;
    @(negedge clk); tick_i = 1'b0;
    while (cyc - t0 < 3) @(negedge clk);
    tick_i = 1'b1; signal_i = 16'sd5000;
    @(negedge clk); tick_i = 1'b0;
    check("ovr_set", overrun_o, 1);
    repeat (22) @(negedge clk);
    check("ovr_single_tick", tick_cnt - base, 1);
    check("ovr_first_value", signal_o, 250);
    apply(16'sd0, 20, got, lat, val);
    check("ovr_buffer_untouched", val, -125);
    check("ovr_sticky", overrun_o, 1);

    // A tick landing in the output cycle is still an overrun
    do_reset();
    base = tick_cnt;
    tick_i = 1'b1; signal_i = 16'sd16384; t0 = cyc;
    @(negedge clk); tick_i = 1'b0;
    while (cyc - t0 < LAT) @(negedge clk);
    check("outcyc_tick_high", tick_o, 1);
    tick_i = 1'b1; signal_i = 16'sd7777;
    @(negedge clk); tick_i = 1'b0;
    check("outcyc_overrun", overrun_o, 1);
    repeat (25) @(negedge clk);
    check("outcyc_single_tick", tick_cnt - base, 1);
    check("outcyc_idle", busy_o, 0);

    // Reset during the MAC aborts the sample entirely
    do_reset();
    base = tick_cnt;
    tick_i = 1'b1; signal_i = 16'sd16384; t0 = cyc;
    @(negedge clk); tick_i = 1'b0;
    while (cyc - t0 < 5) @(negedge clk);
    check("midrst_busy_before", busy_o, 1);
    reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0;
    check("midrst_busy_after", busy_o, 0);
    repeat (25) @(negedge clk);
    check("midrst_no_tick", tick_cnt - base, 0);
    check("midrst_signal_o", signal_o, 0);
    check("midrst_overrun_o", overrun_o, 0);
    apply(16'sd16384, 20, got, lat, val);
    check("midrst_imp0", val, 250);
    apply(16'sd0, 20, got, lat, val);
    check("midrst_imp1", val, -125);
    apply(16'sd0, 20, got, lat, val);
    check("midrst_imp2", val, 500);

    // Random samples at the minimum legal spacing
    do_reset();
    for (int i = 0; i < 40; i++) begin
      xs = 16'($urandom_range(65535, 0));
      model_push(longint'(xs));
      exp_v = model_out();
      apply(xs, N + 3, got, lat, val);
      check($sformatf("b2b%0d_latency", i), lat, LAT);
      check($sformatf("b2b%0d_value", i), val, exp_v);
    end
    check("b2b_no_overrun", overrun_o, 0);

    check("tick_width_one_clock", wide_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cic_compensation_fir.md
Name: cic_compensation_fir

Overview:
- Decimated-rate FIR that flattens the droop of the CIC decimator.
- Sits directly downstream of the CIC decimator.
  - Consumes its MSB-truncated output and its reduced-rate tick.
  - Produces a compensated sample with a one-cycle output tick.
- Uses one time-shared multiplier: one MAC per clock, sequenced by a small FSM over a circular sample buffer.

Parameters:
- NUM_TAPS, 15, number of FIR taps; odd, ≥3.
- NUM_BITS_INPUT, 16, width of signed input samples.
- NUM_BITS_OUTPUT, 16, width of signed output samples.
- NUM_BITS_COEFF, 18, width of signed coefficients.
- COEFF_FRAC_BITS, 17, fractional bits of the coefficients; unity = 2**17.

Ports:
- clk_i  in  1  system clock; one clock only.
- reset_i  in  1  synchronous, active-high reset.
- tick_i  in  1  input sample strobe, one clock wide (CIC tick_reduced_o).
- signal_i  in  NUM_BITS_INPUT  signed input sample, valid when tick_i=1.
- signal_o  out  NUM_BITS_OUTPUT  signed filtered sample, held between updates.
- tick_o  out  1  one-clock pulse when signal_o updates.
- busy_o  out  1  high while a MAC sequence is running.
- overrun_o  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (synchronous, active-high):
  - State → IDLE.
  - signal_o=0, tick_o=0, busy_o=0, overrun_o=0.
  - All NUM_TAPS buffer entries=0; write pointer=0; accumulator=0.
  - Reset mid-sequence aborts it: no tick_o is produced for the aborted sample.
- Buffer:
  - NUM_TAPS-entry circular register array.
  - A write at IDLE+tick_i stores signal_i at wr_ptr.
  - wr_ptr wraps from NUM_TAPS-1 to 0.
  - Tap k reads entry (newest − k) mod NUM_TAPS.
- FSM states IDLE, MAC, ROUND, OUT:
  - IDLE: on tick_i → write sample, clear accumulator, tap counter k=0, go to MAC.
  - MAC: acc += coeff[k] * x[n−k]; k increments each clock; after k=NUM_TAPS−1 → ROUND. Takes NUM_TAPS clocks.
  - ROUND: add 2**(COEFF_FRAC_BITS−1), arithmetic shift right by COEFF_FRAC_BITS, saturate to the signed NUM_BITS_OUTPUT range; register the result → OUT.
  - OUT: update signal_o, tick_o=1 for exactly this cycle → IDLE.
- Timing:
  - busy_o=1 in MAC, ROUND and OUT.
  - Latency from tick_i to tick_o = NUM_TAPS+2 clocks (17 at defaults).
  - Minimum legal tick spacing is NUM_TAPS+3 clocks.
- Overrun:
  - tick_i while busy_o=1 → sample discarded, buffer untouched, overrun_o←1.
  - overrun_o is cleared only by reset.
  - A tick_i in the same cycle the FSM returns to IDLE (the OUT cycle) counts as busy.
- Width rules:
  - Accumulator width = NUM_BITS_INPUT+NUM_BITS_COEFF+$clog2(NUM_TAPS), signed.
  - Products are sign-extended before accumulation; the accumulator never wraps.
- Saturation: values above 2**(NUM_BITS_OUTPUT−1)−1 clamp to max; values below −2**(NUM_BITS_OUTPUT−1) clamp to min.

Optional Feature:
- Macro: CIC_FIR_SYMMETRIC_EN.
- Defined:
  - Coefficients are symmetric; only the first (NUM_TAPS+1)/2 are stored.
  - MAC pre-adds x[n−k]+x[n−(NUM_TAPS−1−k)] into a NUM_BITS_INPUT+1-bit sum; the centre tap is used alone.
  - MAC lasts (NUM_TAPS+1)/2 clocks; latency = (NUM_TAPS+1)/2+2 (10 at defaults); minimum tick spacing = latency+1.
- Undefined: full NUM_TAPS-clock MAC as above.
- Output values are bit-identical in both builds.

Decomposition:
- Package cic_fir_pkg:
  - FSM state enum.
  - Default coefficient array localparam FIR_COEFFS.
    - 15 entries, symmetric.
    - Sum exactly 2**17 (unity DC gain).
    - Alternating-sign sum > 2**17 (Nyquist gain > 1).
  - Accumulator-width function.
- One sub-module, fir_round_saturate: combinational round + shift + clamp, reused by later stages.

Test Plan:
- Impulse: signal_i=16384 for one tick, then zeros at 20-clock spacing → outputs k=0..14 equal round(FIR_COEFFS[k]*16384/2**17); the 16th output = 0.
- DC: constant 1000 at 20-clock spacing → from the 15th output onward signal_o=1000 exactly; tick_o is one clock wide, 17 clocks after each tick_i (10 with CIC_FIR_SYMMETRIC_EN).
- Saturation: alternating +32767/−32768 input → steady-state outputs clamp to exactly +32767 and −32768; no wrap.
- Overrun: second tick_i 3 clocks after the first → overrun_o=1 stays high, one tick_o only, buffer holds only the first sample.
- Reset mid-MAC: assert reset_i for 1 clock at MAC cycle 5 → no tick_o, signal_o=0, overrun_o=0; a following impulse gives a clean impulse response.
- Back-to-back at minimum spacing (18 clocks): 40 random samples → outputs match the golden model; overrun_o stays 0.
